// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - UART transmitter with configurable data width, parity, stop bits and valid/ready input
module uart_tx_cfg #(
   parameter int CLOCK_SPEED  = 100_000_000,
   parameter int BAUD_RATE    = 9600,
   parameter int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 in_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] sreg;
   logic                 par_bit;
   logic                 stop_cnt;
   logic                 tick;

   assign tick     = (cnt == CNT_LAST);
   assign in_ready = (state == S_IDLE);
   assign tx_busy  = (state != S_IDLE);
   assign tx_done  = (state == S_STOP) && tick && (stop_cnt == STOP_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         sreg     <= '0;
         par_bit  <= 1'b0;
         stop_cnt <= 1'b0;
         tx       <= 1'b1;
      end else begin
         if (state == S_IDLE || tick) cnt <= '0;
         else                         cnt <= cnt + CNT_W'(1);

         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  sreg     <= in_data;
                  par_bit  <= (PARITY == 2) ? ~^in_data : ^in_data;
                  bit_idx  <= '0;
                  stop_cnt <= 1'b0;
                  state    <= S_START;
                  tx       <= 1'b0;
               end
            end
            S_START: begin
               if (tick) begin
                  state <= S_DATA;
                  tx    <= sreg[0];
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (bit_idx == IDX_LAST) begin
                     if (PARITY != 0) begin
                        state <= S_PAR;
                        tx    <= par_bit;
                     end else begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     // sreg[1] is the bit that becomes sreg[0] after this shift
                     sreg    <= sreg >> 1;
                     bit_idx <= bit_idx + IDX_W'(1);
                     tx      <= sreg[1];
                  end
               end
            end
            S_PAR: begin
               if (tick) begin
                  state <= S_STOP;
                  tx    <= 1'b1;
               end
            end
            S_STOP: begin
               if (tick) begin
                  if (stop_cnt == STOP_LAST) state <= S_IDLE;
                  else                       stop_cnt <= stop_cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end
endmodule
